// File: rtl/mai_wr_arbiter.sv
// mai_wr_arbiter: shares the single MAC write port between the IF and DM requesters.
// Define MAI_QOS_AGING_EN to let a losing requester's effective QoS grow with each lost arbitration.
//
// state | meaning
// IDLE  | no owner; arbitrate any pending command into grant
// CMD   | owner's command forwarded to the MAC until accepted
// DATA  | owner's data beats forwarded, counted down to the last beat
module mai_wr_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int MW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          iIF_ValidWr,
   input  logic [AW-1:0] iIF_AddrWr,
   input  logic [3:0]    iIF_TagWr,
   input  logic [2:0]    iIF_IdWr,
   input  logic [1:0]    iIF_LenWr,
   input  logic [3:0]    iIF_QoSWr,
   output logic          oIF_ReadyWr,
   input  logic          iIF_DValidWr,
   input  logic [DW-1:0] iIF_DataWr,
   input  logic [MW-1:0] iIF_MaskWr,
   input  logic          iIF_EoD,
   output logic          oIF_DReadyWr,
   input  logic          iDM_ValidWr,
   input  logic [AW-1:0] iDM_AddrWr,
   input  logic [3:0]    iDM_TagWr,
   input  logic [2:0]    iDM_IdWr,
   input  logic [1:0]    iDM_LenWr,
   input  logic [3:0]    iDM_QoSWr,
   output logic          oDM_ReadyWr,
   input  logic          iDM_DValidWr,
   input  logic [DW-1:0] iDM_DataWr,
   input  logic [MW-1:0] iDM_MaskWr,
   input  logic          iDM_EoD,
   output logic          oDM_DReadyWr,
   output logic          oMAC_ValidWr,
   output logic [AW-1:0] oMAC_AddrWr,
   output logic [3:0]    oMAC_TagWr,
   output logic [2:0]    oMAC_IdWr,
   output logic [1:0]    oMAC_LenWr,
   output logic [3:0]    oMAC_QoSWr,
   input  logic          iMAC_ReadyWr,
   output logic          oMAC_DValidWr,
   output logic [DW-1:0] oMAC_DataWr,
   output logic [MW-1:0] oMAC_MaskWr,
   output logic          oMAC_EoD,
   input  logic          iMAC_DReadyWr,
   output logic [1:0]    oGrant,
   output logic          oErr
);

   typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2} stateT;

   stateT         state;
   logic [1:0]    grant;
   logic          rrPtr;
   logic [2:0]    beatCnt;
   logic          errPulse;

   logic [3:0]    effIf, effDm;
   logic          ifWins;
   logic          ownDm;
   logic          ownValid, ownDValid, ownEoD;
   logic [AW-1:0] ownAddr;
   logic [3:0]    ownTag, ownQoS;
   logic [2:0]    ownId;
   logic [1:0]    ownLen;
   logic [DW-1:0] ownData;
   logic [MW-1:0] ownMask;

   assign ownDm     = grant[1];
   assign ownValid  = ownDm ? iDM_ValidWr  : iIF_ValidWr;
   assign ownAddr   = ownDm ? iDM_AddrWr   : iIF_AddrWr;
   assign ownTag    = ownDm ? iDM_TagWr    : iIF_TagWr;
   assign ownId     = ownDm ? iDM_IdWr     : iIF_IdWr;
   assign ownLen    = ownDm ? iDM_LenWr    : iIF_LenWr;
   assign ownQoS    = ownDm ? iDM_QoSWr    : iIF_QoSWr;
   assign ownDValid = ownDm ? iDM_DValidWr : iIF_DValidWr;
   assign ownData   = ownDm ? iDM_DataWr   : iIF_DataWr;
   assign ownMask   = ownDm ? iDM_MaskWr   : iIF_MaskWr;
   assign ownEoD    = ownDm ? iDM_EoD      : iIF_EoD;

`ifdef MAI_QOS_AGING_EN
   logic [3:0] ageIf, ageDm;

   function automatic logic [3:0] satAdd(input logic [3:0] a, input logic [3:0] b);
      logic [4:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[4] ? 4'd15 : s[3:0];
   endfunction

   assign effIf = satAdd(iIF_QoSWr, ageIf);
   assign effDm = satAdd(iDM_QoSWr, ageDm);

   // Winner's age clears; a requester that was waiting and lost ages by one.
   always_ff @(posedge clk) begin
      if (reset) begin
         ageIf <= '0;
         ageDm <= '0;
      end else if (state == IDLE && (iIF_ValidWr || iDM_ValidWr)) begin
         if (ifWins) begin
            ageIf <= '0;
            if (iDM_ValidWr) ageDm <= satAdd(ageDm, 4'd1);
         end else begin
            ageDm <= '0;
            if (iIF_ValidWr) ageIf <= satAdd(ageIf, 4'd1);
         end
      end
   end
`else
   assign effIf = iIF_QoSWr;
   assign effDm = iDM_QoSWr;
`endif

   assign ifWins = iIF_ValidWr &
                   (~iDM_ValidWr | (effIf > effDm) | ((effIf == effDm) & ~rrPtr));

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         grant    <= 2'b00;
         rrPtr    <= 1'b0;
         beatCnt  <= 3'd0;
         errPulse <= 1'b0;
      end else begin
         errPulse <= 1'b0;
         unique case (state)
            IDLE: begin
               if (iIF_ValidWr || iDM_ValidWr) begin
                  grant <= ifWins ? 2'b01 : 2'b10;
                  state <= CMD;
               end
            end
            CMD: begin
               if (ownValid && iMAC_ReadyWr) begin
                  beatCnt <= (ownLen == 2'd0) ? 3'd4 : {1'b0, ownLen};
                  state   <= DATA;
               end
            end
            DATA: begin
               // The burst ends on the internal count; the requester's EoD is only audited.
               if (ownDValid && iMAC_DReadyWr) begin
                  errPulse <= ownEoD != (beatCnt == 3'd1);
                  beatCnt  <= beatCnt - 3'd1;
                  if (beatCnt == 3'd1) begin
                     state <= IDLE;
                     grant <= 2'b00;
                     rrPtr <= grant[0];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      oMAC_ValidWr  = 1'b0;
      oMAC_AddrWr   = '0;
      oMAC_TagWr    = '0;
      oMAC_IdWr     = '0;
      oMAC_LenWr    = '0;
      oMAC_QoSWr    = '0;
      oMAC_DValidWr = 1'b0;
      oMAC_DataWr   = '0;
      oMAC_MaskWr   = '0;
      oMAC_EoD      = 1'b0;
      oIF_ReadyWr   = 1'b0;
      oDM_ReadyWr   = 1'b0;
      oIF_DReadyWr  = 1'b0;
      oDM_DReadyWr  = 1'b0;
      if (state == CMD) begin
         oMAC_ValidWr = ownValid;
         if (ownValid) begin
            oMAC_AddrWr = ownAddr;
            oMAC_TagWr  = ownTag;
            oMAC_IdWr   = ownId;
            oMAC_LenWr  = ownLen;
            oMAC_QoSWr  = ownQoS;
         end
         oIF_ReadyWr = grant[0] & iMAC_ReadyWr;
         oDM_ReadyWr = grant[1] & iMAC_ReadyWr;
      end
      if (state == DATA) begin
         oMAC_DValidWr = ownDValid;
         if (ownDValid) begin
            oMAC_DataWr = ownData;
            oMAC_MaskWr = ownMask;
            oMAC_EoD    = beatCnt == 3'd1;
         end
         oIF_DReadyWr = grant[0] & iMAC_DReadyWr;
         oDM_DReadyWr = grant[1] & iMAC_DReadyWr;
      end
   end

   assign oGrant = grant;
   assign oErr   = errPulse;

endmodule
